toy_fp_issue_buf: RTL

TOY_FP_ISSUE_BUF -- requirements
Module: toy_fp_issue_buf

---
 rtl/toy_pack.sv | 10 +
 rtl/toy_sync_fifo.sv | 47 ++++
 rtl/toy_fp_issue_buf.sv | 107 ++++++++++
 3 files changed

// File: rtl/toy_pack.sv
// toy_pack: shared types for the FP issue buffer (instruction payload, FSM states)
package toy_pack;
    localparam int INST_IDX_WIDTH = 4;
    typedef struct packed {
        logic [3:0]                op;
        logic [7:0]                imm;
        logic [INST_IDX_WIDTH-1:0] inst_idx;
    } eu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fsm_e;
endpackage

// File: rtl/toy_sync_fifo.sv
// toy_sync_fifo: DEPTH-entry payload FIFO with wrap-bit pointers and flush clear
// Ports: clk/rst, flush (clear pointers), push/wdata, pop/rdata (head),
//        full, empty, count (entries held)
module toy_sync_fifo
    import toy_pack::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  eu_pkg       wdata,
    input  logic        pop,
    output eu_pkg       rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    eu_pkg       mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        wr_en, rd_en;

    assign wr_en = push & !full & !flush;
    assign rd_en = pop & !empty & !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
            if (rd_en) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = wptr_q == rptr_q;
    assign count = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];
endmodule

// File: rtl/toy_fp_issue_buf.sv
// toy_fp_issue_buf: in-order single-in-flight issue buffer for an FP execution unit
// Ports: in_vld/in_rdy/in_pld (dispatch push), flush, fp_vld/fp_rdy/fp_pld (issue),
//        fp_inst_commit_en/fp_reg_inst_idx (completion), occupancy, busy,
//        err_idx / err_timeout (sticky error flags)
module toy_fp_issue_buf
    import toy_pack::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  eu_pkg                     in_pld,
    input  logic                      flush,
    output logic                      fp_vld,
    input  logic                      fp_rdy,
    output eu_pkg                     fp_pld,
    input  logic                      fp_inst_commit_en,
    input  logic [INST_IDX_WIDTH-1:0] fp_reg_inst_idx,
    output logic [AW:0]               occupancy,
    output logic                      busy,
    output logic                      err_idx,
    output logic                      err_timeout
);
    fsm_e                      state_q, state_d;
    logic [INST_IDX_WIDTH-1:0] inflight_q, inflight_d;
    logic [TW-1:0]             wcnt_q, wcnt_d;
    logic                      err_idx_q, err_idx_d, err_to_q, err_to_d;
    logic                      full, empty, push, issue, timeout, more;
    eu_pkg                     head;

    assign push  = in_vld & in_rdy;
    assign issue = fp_vld & fp_rdy;

    toy_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (in_pld),
        .pop   (issue),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            wcnt_q     <= '0;
            err_idx_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            wcnt_q     <= wcnt_d;
            err_idx_q  <= err_idx_d;
            err_to_q   <= err_to_d;
        end
    end

    // A completion only closes the wait; a silent unit is abandoned after TIMEOUT cycles.
    assign timeout = (state_q == WAIT) && !fp_inst_commit_en && (wcnt_q == TW'(TIMEOUT - 1));
    // WAIT never pops, so post-event occupancy is the current count plus this cycle's push.
    assign more    = !flush && (!empty || push);

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        wcnt_d     = wcnt_q;
        err_to_d   = err_to_q | timeout;
        err_idx_d  = err_idx_q | (fp_inst_commit_en &
                     ((state_q != WAIT) | (fp_reg_inst_idx != inflight_q)));
        case (state_q)
            IDLE: state_d = (!empty && !flush) ? REQ : IDLE;
            REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (issue) begin
                    state_d    = WAIT;
                    inflight_d = head.inst_idx;
                    wcnt_d     = '0;
                end
            end
            WAIT: begin
                if (fp_inst_commit_en || timeout) state_d = more ? REQ : IDLE;
                else wcnt_d = wcnt_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy      = !rst && !full && !flush;
        fp_vld      = (state_q == REQ) && !flush;
        fp_pld      = head;
        busy        = (occupancy != '0) || (state_q != IDLE);
        err_idx     = err_idx_q;
        err_timeout = err_to_q;
    end
endmodule
